regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter and scoreboard for the single-write-port integer register file in the WB stage. Shares the register-file write port between the in-order pipeline writeback and one long-latency unit (divider/load miss path). Tracks registers with outstanding long-latency writes and raises a decode stall on RAW/WAW hazards. A starvation guard guarantees long-latency writeback progress.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive denied cycles of a pending long-latency write before it is forced through (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  pipeline writeback request.
- wb_addr  in  5  pipeline destination register.
- wb_data  in  32  pipeline writeback data.
- wb_ready  out  1  pipeline writeback accepted; pipeline holds WB stage when low.
- lu_valid  in  1  long-latency unit writeback request.
- lu_addr  in  5  long-latency destination register.
- lu_data  in  32  long-latency writeback data.
- lu_ready  out  1  long-latency writeback accepted this cycle.
- issue_valid  in  1  a long-latency op issues this cycle.
- issue_rd  in  5  destination of the issuing long-latency op.
- dec_rs1, dec_rs2, dec_rd  in  5 each  register addresses of the instruction in decode.
- dec_stall  out  1  decode must stall (hazard on a busy register).
- rf_wr_en  out  1  register file write enable.
- rf_wr_addr  out  5  register file write address.
- rf_data_in  out  32  register file write data.

## Operation
- State: busy[31:1] scoreboard bits; starve_cnt saturating counter (4 bits).
- Grant (combinational, per cycle):
  - force = lu_valid && starve_cnt == STARVE_LIMIT.
  - force: grant LU; wb_ready = 0; lu_ready = 1.
  - else wb_valid: grant WB; wb_ready = 1; lu_ready = 0.
  - else lu_valid: grant LU; lu_ready = 1; wb_ready = 1.
  - neither: no grant; wb_ready = 1; lu_ready = 0.
- Write port: rf_wr_en = granted source valid && granted addr != 0; rf_wr_addr/rf_data_in from granted source, else 0. Writes to x0 are accepted (handshake completes) but never drive rf_wr_en.
- Starvation counter: lu_valid && !lu_ready -> increment, saturate at STARVE_LIMIT; lu_ready or !lu_valid -> clear to 0.
- Scoreboard:
  - issue_valid && issue_rd != 0 -> set busy[issue_rd] next cycle.
  - lu_valid && lu_ready && lu_addr != 0 -> clear busy[lu_addr] next cycle.
  - Set and clear of the same register in one cycle: set wins.
  - busy[0] constant 0.
- dec_stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd], from registered busy only; a clear becomes visible the cycle after the LU grant.

## Timing
- Reset: busy all 0, starve_cnt 0; outputs: wb_ready 1, lu_ready 0, dec_stall 0, rf_wr_en 0, rf_wr_addr 0, rf_data_in 0 (with inputs idle).
- Grant and write-port outputs: zero-latency combinational; write lands in the register file at the same rising edge.
- Scoreboard and counter: update at rising edge; one-cycle latency to dec_stall.
- Forced grant lasts exactly one cycle; counter returns to 0 on that grant.
- Reset asserted mid-operation: all state cleared immediately; pending LU request must be re-presented.

## Configuration
- REGFILE_ARB_STARVE_GUARD_EN defined: starvation counter and forced grant present as above.
- Not defined: no counter; strict fixed priority WB > LU; wb_ready tied to 1; LU may wait indefinitely.

## Test plan
- Reset: hold reset_n low with random inputs -> wb_ready 1, lu_ready 0, rf_wr_en 0, dec_stall 0; release, no spurious writes.
- Conflict: wb_valid (x5, 0x11) and lu_valid (x6, 0x22) same cycle, guard off -> x5 written, lu_ready 0; next cycle wb_valid 0 -> x6 written.
- Starvation, STARVE_LIMIT 4: wb_valid held, lu_valid held -> lu_ready 0 for 4 cycles, 5th cycle lu_ready 1, wb_ready 0, LU data written; next cycle WB resumes.
- Scoreboard: issue_rd x7; next cycle dec_rs1 x7 -> dec_stall 1; LU writes x7 -> dec_stall 0 the following cycle.
- Same-cycle set/clear: LU grant x9 while issue_rd x9 -> busy[9] stays 1, dec_rd x9 stalls.
- x0: lu_addr 0 granted -> lu_ready 1, rf_wr_en 0; issue_rd 0 -> dec_stall never asserts for x0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter (pipeline WB vs. long-latency unit) with a busy scoreboard.
// Optional starvation guard for the long-latency path: define REGFILE_ARB_STARVE_GUARD_EN.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  input  logic        lu_valid,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        dec_stall,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_data_in
);

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned CW   = 4;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("regfile_wb_arbiter: STARVE_LIMIT out of range 1..15");
  end

  logic            force_lu;
  logic            gnt_wb;
  logic            gnt_lu;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

`ifdef REGFILE_ARB_STARVE_GUARD_EN
  logic [CW-1:0] starve_cnt;

  // Counts consecutive denied cycles of a pending LU write; any grant or idle clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (lu_valid && !lu_ready) begin
      if (starve_cnt != CW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + CW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  assign force_lu = lu_valid && (starve_cnt == CW'(STARVE_LIMIT));
`else
  assign force_lu = 1'b0;
`endif

  // Grant selection; reset holds the port idle regardless of requests.
  always_comb begin
    wb_ready = 1'b1;
    lu_ready = 1'b0;
    gnt_wb   = 1'b0;
    gnt_lu   = 1'b0;
    if (reset_n) begin
      if (force_lu) begin
        gnt_lu   = 1'b1;
        wb_ready = 1'b0;
        lu_ready = 1'b1;
      end else if (wb_valid) begin
        gnt_wb = 1'b1;
      end else if (lu_valid) begin
        gnt_lu   = 1'b1;
        lu_ready = 1'b1;
      end
    end
  end

  // Write port mux; x0 writes complete the handshake but never enable the write.
  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_data_in = '0;
    if (gnt_wb) begin
      rf_wr_en   = (wb_addr != AW'(0));
      rf_wr_addr = wb_addr;
      rf_data_in = wb_data;
    end else if (gnt_lu) begin
      rf_wr_en   = (lu_addr != AW'(0));
      rf_wr_addr = lu_addr;
      rf_data_in = lu_data;
    end
  end

  // Scoreboard next state: clear applied first so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (gnt_lu && lu_addr != AW'(0)) busy_nxt[lu_addr] = 1'b0;
    if (issue_valid && issue_rd != AW'(0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign dec_stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];

  logic unused_dw;
  assign unused_dw = (DW == 32);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (works with or without REGFILE_ARB_STARVE_GUARD_EN).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        wb_ready;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_addr = '0;
  logic [31:0] lu_data = '0;
  logic        lu_ready;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  dec_rs1 = '0;
  logic [4:0]  dec_rs2 = '0;
  logic [4:0]  dec_rd = '0;
  logic        dec_stall;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_data_in;

  int passed = 0;
  int total  = 0;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_stall(dec_stall),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_data_in(rf_data_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      step();
      wb_valid = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
      lu_valid = 1'($urandom); lu_addr = 5'($urandom); lu_data = $urandom;
      issue_valid = 1'($urandom); issue_rd = 5'($urandom);
      dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom); dec_rd = 5'($urandom);
      #1;
      check("rst_wb_ready", 32'(wb_ready), 32'd1);
      check("rst_lu_ready", 32'(lu_ready), 32'd0);
      check("rst_wr_en", 32'(rf_wr_en), 32'd0);
      check("rst_dec_stall", 32'(dec_stall), 32'd0);
    end
    step(); idle(); reset_n = 1'b1; #1;
    check("rel_wr_en", 32'(rf_wr_en), 32'd0);
    check("rel_wr_addr", 32'(rf_wr_addr), 32'd0);
    check("rel_data", rf_data_in, 32'd0);
    step(); dec_rs1 = 5'd31; dec_rs2 = 5'd1; dec_rd = 5'd17; #1;
    check("rel_no_busy", 32'(dec_stall), 32'd0);

    // Conflict: WB wins, LU follows when WB drops
    step(); idle();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h11;
    lu_valid = 1'b1; lu_addr = 5'd6; lu_data = 32'h22; #1;
    check("cf_wr_en", 32'(rf_wr_en), 32'd1);
    check("cf_addr", 32'(rf_wr_addr), 32'd5);
    check("cf_data", rf_data_in, 32'h11);
    check("cf_lu_ready", 32'(lu_ready), 32'd0);
    check("cf_wb_ready", 32'(wb_ready), 32'd1);
    step(); wb_valid = 1'b0; #1;
    check("cf2_addr", 32'(rf_wr_addr), 32'd6);
    check("cf2_data", rf_data_in, 32'h22);
    check("cf2_lu_ready", 32'(lu_ready), 32'd1);
    check("cf2_wb_ready", 32'(wb_ready), 32'd1);

    // Starvation: WB and LU both held
    step(); idle();
    wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'hAAAA;
    lu_valid = 1'b1; lu_addr = 5'd11; lu_data = 32'hBBBB;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) step();
      #1;
`ifdef REGFILE_ARB_STARVE_GUARD_EN
      if (c == 5) begin
        check("sv_force_lu_ready", 32'(lu_ready), 32'd1);
        check("sv_force_wb_ready", 32'(wb_ready), 32'd0);
        check("sv_force_addr", 32'(rf_wr_addr), 32'd11);
        check("sv_force_data", rf_data_in, 32'hBBBB);
      end else begin
        check("sv_lu_ready", 32'(lu_ready), 32'd0);
        check("sv_wb_ready", 32'(wb_ready), 32'd1);
        check("sv_addr", 32'(rf_wr_addr), 32'd10);
      end
`else
      check("sv_lu_ready", 32'(lu_ready), 32'd0);
      check("sv_wb_ready", 32'(wb_ready), 32'd1);
      check("sv_addr", 32'(rf_wr_addr), 32'd10);
      check("sv_data", rf_data_in, 32'hAAAA);
`endif
    end

    // Scoreboard set by issue, cleared by LU write
    step(); idle(); issue_valid = 1'b1; issue_rd = 5'd7; dec_rs1 = 5'd7; #1;
    check("sb_same_cycle", 32'(dec_stall), 32'd0);
    step(); issue_valid = 1'b0; #1;
    check("sb_rs1_stall", 32'(dec_stall), 32'd1);
    step(); lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h77; #1;
    check("sb_lu_ready", 32'(lu_ready), 32'd1);
    check("sb_still_stall", 32'(dec_stall), 32'd1);
    step(); lu_valid = 1'b0; #1;
    check("sb_cleared", 32'(dec_stall), 32'd0);

    // Same-cycle set and clear of x9: set wins
    step(); idle(); issue_valid = 1'b1; issue_rd = 5'd9; dec_rd = 5'd9;
    step(); lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h99; #1;
    check("sc_lu_ready", 32'(lu_ready), 32'd1);
    check("sc_stall_a", 32'(dec_stall), 32'd1);
    step(); issue_valid = 1'b0; lu_valid = 1'b0; #1;
    check("sc_stall_b", 32'(dec_stall), 32'd1);
    step(); lu_valid = 1'b1; #1;
    step(); lu_valid = 1'b0; #1;
    check("sc_cleared", 32'(dec_stall), 32'd0);

    // x0 handling
    step(); idle(); lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hDEAD;
    issue_valid = 1'b1; issue_rd = 5'd0; #1;
    check("x0_lu_ready", 32'(lu_ready), 32'd1);
    check("x0_lu_wr_en", 32'(rf_wr_en), 32'd0);
    step(); idle(); wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hBEEF; #1;
    check("x0_wb_ready", 32'(wb_ready), 32'd1);
    check("x0_wb_wr_en", 32'(rf_wr_en), 32'd0);
    check("x0_no_stall", 32'(dec_stall), 32'd0);

    // Mid-operation reset clears scoreboard immediately
    step(); idle(); issue_valid = 1'b1; issue_rd = 5'd3; dec_rs2 = 5'd3;
    step(); issue_valid = 1'b0; #1;
    check("mr_stall", 32'(dec_stall), 32'd1);
    lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h33;
    #1 reset_n = 1'b0; #1;
    check("mr_stall_cleared", 32'(dec_stall), 32'd0);
    check("mr_lu_ready", 32'(lu_ready), 32'd0);
    check("mr_wr_en", 32'(rf_wr_en), 32'd0);
    step(); reset_n = 1'b1; #1;
    check("mr_lu_regrant", 32'(lu_ready), 32'd1);
    check("mr_lu_addr", 32'(rf_wr_addr), 32'd3);
    step(); idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
